// File: rtl/video_upscale_2x.sv
// video_upscale_2x
//   Integer 2x upscaler. Each accepted n-bit source pixel leaves as one 2n-bit
//   pair {p,p}, which doubles the line horizontally. Every input line is kept in
//   a line buffer and replayed once, which doubles the frame vertically.
//
//   Ports:
//     clk       pixel-pair clock (FIFO write clock)
//     rst       asynchronous active-high reset
//     in_data   source pixel (RGB565 when n=16)
//     in_valid  in_data is valid
//     in_ready  pixel is accepted this cycle (in_valid & in_ready)
//     in_sof    accepted pixel is the first pixel of a frame (forces x=0,y=0)
//     cke       downstream may take data (~FIFO almost-full)
//     data_o    pixel pair {left,right}
//     we_o      one-cycle write strobe for data_o
//     sof_o     marks the first pair of each output frame
//
//   Parameters: h (output width), v (output height), n (pixel width).
//
//   Optional build macro UPSCALE_SCANLINE_EN: pairs replayed from the line
//   buffer are darkened by halving each RGB565 field (n must be 16).
module video_upscale_2x #(
  parameter int h = 1920,
  parameter int v = 1080,
  parameter int n = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [n-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_sof,
  input  logic           cke,
  output logic [2*n-1:0] data_o,
  output logic           we_o,
  output logic           sof_o
);

  localparam int HW = h / 2;
  localparam int XW = (HW > 1) ? $clog2(HW) : 1;
  localparam int YW = (v > 1) ? $clog2(v) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(HW - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(v - 1);
  localparam logic [XW-1:0] X_ZERO = {XW{1'b0}};
  localparam logic [YW-1:0] Y_ZERO = {YW{1'b0}};

  typedef enum logic [0:0] {
    PASS   = 1'b0,
    REPEAT = 1'b1
  } state_t;

  state_t        state_r;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic          rd_vld_r;   // rd_data_r holds a replay pixel due out next edge
  logic [n-1:0]  rd_data_r;
  logic [n-1:0]  linebuf_r [0:HW-1];

  logic          accept_s;
  logic          rd_issue_s;
  logic [XW-1:0] wr_x_s;
  logic [YW-1:0] wr_y_s;
  logic [n-1:0]  rep_s;

`ifdef UPSCALE_SCANLINE_EN
  // Halve each RGB565 field: R, G and B each shifted right by one.
  function automatic logic [15:0] half_rgb565(input logic [15:0] p);
    return {1'b0, p[15:12], 1'b0, p[10:6], 1'b0, p[4:1]};
  endfunction
`endif

  // The replay read that returns on the same edge a new accept would land
  // must win the output register, so input is held off while it is pending.
  assign in_ready = cke & ~rst & (state_r == PASS) & ~rd_vld_r;

  // Handshake decode and resync address selection.
  always_comb begin
    accept_s   = in_valid & in_ready;
    rd_issue_s = (state_r == REPEAT) & cke;
    if (in_sof) begin
      wr_x_s = X_ZERO;
      wr_y_s = Y_ZERO;
    end else begin
      wr_x_s = x_r;
      wr_y_s = y_r;
    end
  end

  // Replay pixel, optionally darkened, feeding the output register.
  always_comb begin
`ifdef UPSCALE_SCANLINE_EN
    rep_s = half_rgb565(rd_data_r);
`else
    rep_s = rd_data_r;
`endif
  end

  // Line buffer: written on accept, read with one-cycle latency in REPEAT.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      linebuf_r[wr_x_s] <= in_data;
    end
    if (rd_issue_s) begin
      rd_data_r <= linebuf_r[x_r];
    end
  end

  // Control FSM, line/frame counters and registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= PASS;
      x_r      <= X_ZERO;
      y_r      <= Y_ZERO;
      rd_vld_r <= 1'b0;
      data_o   <= {(2*n){1'b0}};
      we_o     <= 1'b0;
      sof_o    <= 1'b0;
    end else begin
      rd_vld_r <= rd_issue_s;

      if (rd_vld_r) begin
        data_o <= {rep_s, rep_s};
        we_o   <= 1'b1;
        sof_o  <= 1'b0;
      end else if (accept_s) begin
        data_o <= {in_data, in_data};
        we_o   <= 1'b1;
        sof_o  <= (wr_x_s == X_ZERO) && (wr_y_s == Y_ZERO);
      end else begin
        we_o  <= 1'b0;
        sof_o <= 1'b0;
      end

      case (state_r)
        PASS: begin
          if (accept_s) begin
            if (wr_x_s == X_LAST) begin
              x_r     <= X_ZERO;
              y_r     <= wr_y_s + YW'(1);
              state_r <= REPEAT;
            end else begin
              x_r <= wr_x_s + XW'(1);
              y_r <= wr_y_s;
            end
          end
        end
        REPEAT: begin
          if (rd_issue_s) begin
            if (x_r == X_LAST) begin
              x_r     <= X_ZERO;
              state_r <= PASS;
              y_r     <= (y_r == Y_LAST) ? Y_ZERO : (y_r + YW'(1));
            end else begin
              x_r <= x_r + XW'(1);
            end
          end
        end
        default: begin
          state_r <= PASS;
          x_r     <= X_ZERO;
          y_r     <= Y_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_upscale_2x.sv
// Testbench for video_upscale_2x: small-frame directed tables (h=8, v=4) plus
// a continuous-stream instance (h=32, v=16) for rate and frame counting.
module tb_video_upscale_2x;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid, in_ready, in_sof, cke;
  logic [31:0] data_o;
  logic        we_o, sof_o;

  logic        b_rst;
  logic [15:0] b_in_data;
  logic        b_in_valid, b_in_ready, b_in_sof, b_cke;
  logic [31:0] b_data_o;
  logic        b_we_o, b_sof_o;

  always #5 clk = ~clk;

  video_upscale_2x #(.h(8), .v(4), .n(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_sof(in_sof), .cke(cke),
    .data_o(data_o), .we_o(we_o), .sof_o(sof_o));

  video_upscale_2x #(.h(32), .v(16), .n(16)) dut_big (
    .clk(clk), .rst(b_rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_sof(b_in_sof), .cke(b_cke),
    .data_o(b_data_o), .we_o(b_we_o), .sof_o(b_sof_o));

  typedef struct packed { logic [31:0] d; logic s; } pair_t;
  typedef struct { logic [15:0] pix; logic feed_sof; logic feed; logic [31:0] exp_d; logic exp_s; } vec_t;

  int    tests = 0;
  int    fails = 0;
  pair_t got_q[$];
  int    cke0_pulses;
  bit    chk_ready;
  bit    ready_viol;
  logic  cke_edge;
  vec_t  basic_tbl[16];
  vec_t  resync_tbl[18];
  vec_t  cur[$];

  function automatic logic [31:0] rep32(input logic [15:0] p);
`ifdef UPSCALE_SCANLINE_EN
    logic [15:0] q;
    q = {1'b0, p[15:12], 1'b0, p[10:6], 1'b0, p[4:1]};
    return {q, q};
`else
    return {p, p};
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cke_edge <= cke;

  // Output monitor for the small instance.
  always @(negedge clk) begin
    if (we_o) begin
      got_q.push_back({data_o, sof_o});
      if (!cke_edge) cke0_pulses++;
    end
    if (chk_ready && ((got_q.size() % 8) >= 4) && in_ready) ready_viol = 1'b1;
  end

  // Present one pixel from a negedge until accepted; returns on a negedge.
  task automatic feed(input logic [15:0] pix, input logic sof, output bit ok);
    bit acc;
    ok = 1'b0;
    in_data = pix; in_sof = sof; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      #1 acc = in_ready;
      @(negedge clk);
      if (acc) begin ok = 1'b1; break; end
    end
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic wait_pulses(input int k);
    for (int c = 0; c < 300 && got_q.size() < k; c++) @(negedge clk);
    repeat (6) @(negedge clk);
  endtask

  task automatic run_vecs(input string name, input bit bp);
    int nfail_feed;
    bit ok;
    nfail_feed = 0;
    got_q.delete();
    cke0_pulses = 0;
    ready_viol  = 1'b0;
    fork
      begin
        foreach (cur[i]) if (cur[i].feed) begin
          feed(cur[i].pix, cur[i].feed_sof, ok);
          if (!ok) nfail_feed++;
        end
      end
      begin
        if (bp) begin
          for (int c = 0; c < 300 && got_q.size() < 6; c++) @(negedge clk);
          cke = 1'b0;
          repeat (5) @(negedge clk);
          cke = 1'b1;
        end
      end
    join
    wait_pulses(cur.size());
    chk({name, "_feed_timeouts"}, nfail_feed, 0);
    chk({name, "_pulse_count"}, got_q.size(), cur.size());
    foreach (cur[i]) begin
      logic [63:0] a;
      a = 'x;
      if (i < got_q.size()) a = {31'd0, got_q[i]};
      chk($sformatf("%s[%0d]", name, i), a, {31'd0, cur[i].exp_d, cur[i].exp_s});
    end
  endtask

  initial begin
    bit ok;
    int k, f, kf, lp, pos, src, data_err, sofs, acc_cnt, c0, c1;
    bit acc;
    logic [31:0] exp_d;

    // Basic frame: pixels 1..8, line buffer replay after each input line.
    basic_tbl = '{
      '{16'd1, 1'b1, 1'b1, 32'h0001_0001, 1'b1}, '{16'd2, 1'b0, 1'b1, 32'h0002_0002, 1'b0},
      '{16'd3, 1'b0, 1'b1, 32'h0003_0003, 1'b0}, '{16'd4, 1'b0, 1'b1, 32'h0004_0004, 1'b0},
      '{16'd0, 1'b0, 1'b0, rep32(16'd1), 1'b0},  '{16'd0, 1'b0, 1'b0, rep32(16'd2), 1'b0},
      '{16'd0, 1'b0, 1'b0, rep32(16'd3), 1'b0},  '{16'd0, 1'b0, 1'b0, rep32(16'd4), 1'b0},
      '{16'd5, 1'b0, 1'b1, 32'h0005_0005, 1'b0}, '{16'd6, 1'b0, 1'b1, 32'h0006_0006, 1'b0},
      '{16'd7, 1'b0, 1'b1, 32'h0007_0007, 1'b0}, '{16'd8, 1'b0, 1'b1, 32'h0008_0008, 1'b0},
      '{16'd0, 1'b0, 1'b0, rep32(16'd5), 1'b0},  '{16'd0, 1'b0, 1'b0, rep32(16'd6), 1'b0},
      '{16'd0, 1'b0, 1'b0, rep32(16'd7), 1'b0},  '{16'd0, 1'b0, 1'b0, rep32(16'd8), 1'b0}};
    // Resync on the 3rd pixel of the 2nd input line: it restarts line 0.
    resync_tbl = '{
      '{16'd1, 1'b1, 1'b1, 32'h0001_0001, 1'b1}, '{16'd2, 1'b0, 1'b1, 32'h0002_0002, 1'b0},
      '{16'd3, 1'b0, 1'b1, 32'h0003_0003, 1'b0}, '{16'd4, 1'b0, 1'b1, 32'h0004_0004, 1'b0},
      '{16'd0, 1'b0, 1'b0, rep32(16'd1), 1'b0},  '{16'd0, 1'b0, 1'b0, rep32(16'd2), 1'b0},
      '{16'd0, 1'b0, 1'b0, rep32(16'd3), 1'b0},  '{16'd0, 1'b0, 1'b0, rep32(16'd4), 1'b0},
      '{16'd5, 1'b0, 1'b1, 32'h0005_0005, 1'b0}, '{16'd6, 1'b0, 1'b1, 32'h0006_0006, 1'b0},
      '{16'd7, 1'b1, 1'b1, 32'h0007_0007, 1'b1}, '{16'd8, 1'b0, 1'b1, 32'h0008_0008, 1'b0},
      '{16'd9, 1'b0, 1'b1, 32'h0009_0009, 1'b0}, '{16'd10, 1'b0, 1'b1, 32'h000A_000A, 1'b0},
      '{16'd0, 1'b0, 1'b0, rep32(16'd7), 1'b0},  '{16'd0, 1'b0, 1'b0, rep32(16'd8), 1'b0},
      '{16'd0, 1'b0, 1'b0, rep32(16'd9), 1'b0},  '{16'd0, 1'b0, 1'b0, rep32(16'd10), 1'b0}};

    rst = 1'b1; b_rst = 1'b1; cke = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = 16'd0;
    b_cke = 1'b1; b_in_valid = 1'b0; b_in_sof = 1'b0; b_in_data = 16'd0;
    chk_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_we", we_o, 0);
    chk("reset_data", data_o, 0);
    chk("reset_sof", sof_o, 0);
    chk("reset_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic frame, then the same frame with a 5-cycle cke drop mid-REPEAT.
    chk_ready = 1'b1;
    cur.delete(); foreach (basic_tbl[i]) cur.push_back(basic_tbl[i]);
    run_vecs("basic", 1'b0);
    chk("basic_ready_in_repeat", ready_viol, 0);
    run_vecs("bp", 1'b1);
    chk("bp_ready_in_repeat", ready_viol, 0);
    chk("bp_pulses_while_cke0", (cke0_pulses <= 1), 1);
    chk_ready = 1'b0;

    cur.delete(); foreach (resync_tbl[i]) cur.push_back(resync_tbl[i]);
    run_vecs("resync", 1'b0);

    // Asynchronous reset in the middle of a REPEAT line.
    got_q.delete();
    for (int p = 1; p <= 4; p++) begin
      feed(16'(p), (p == 1), ok);
      chk($sformatf("rst_feed%0d", p), ok, 1);
    end
    for (int c = 0; c < 100 && got_q.size() < 6; c++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_we", we_o, 0);
    chk("rst_mid_data", data_o, 0);
    chk("rst_mid_sof", sof_o, 0);
    chk("rst_mid_in_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    feed(16'h00AA, 1'b0, ok);
    wait_pulses(1);
    chk("post_rst_count", got_q.size(), 1);
    chk("post_rst_pair", (got_q.size() > 0) ? {31'd0, got_q[0]} : 64'hx, {31'd0, 32'h00AA_00AA, 1'b1});

    // Scanline darkening on the replayed copy of a white pixel.
    got_q.delete();
    feed(16'hFFFF, 1'b1, ok);
    for (int p = 0; p < 3; p++) feed(16'h0000, 1'b0, ok);
    wait_pulses(8);
    chk("scan_count", got_q.size(), 8);
    chk("scan_pass", (got_q.size() > 0) ? got_q[0].d : 32'hx, 32'hFFFF_FFFF);
`ifdef UPSCALE_SCANLINE_EN
    chk("scan_repeat", (got_q.size() > 4) ? got_q[4].d : 32'hx, 32'h7BEF_7BEF);
`else
    chk("scan_repeat", (got_q.size() > 4) ? got_q[4].d : 32'hx, 32'hFFFF_FFFF);
`endif

    // Continuous stream, cke=1: two frames of 16 pairs x 16 lines.
    @(negedge clk);
    b_rst = 1'b0; b_in_valid = 1'b1; b_in_sof = 1'b1; b_in_data = 16'd0;
    acc_cnt = 0; k = 0; data_err = 0; sofs = 0; c0 = -1; c1 = -1;
    for (int c = 0; c < 2000 && k < 512; c++) begin
      #1 acc = b_in_ready;
      @(negedge clk);
      if (b_we_o) begin
        f = k / 256; kf = k % 256; lp = kf / 32; pos = kf % 32;
        src = f * 128 + lp * 16 + (pos % 16);
        exp_d = (pos >= 16) ? rep32(16'(src)) : {16'(src), 16'(src)};
        if (b_data_o !== exp_d || b_sof_o !== (kf == 0)) begin
          if (data_err == 0) $display("stream pulse %0d: got %h/%b, expected %h/%b", k, b_data_o, b_sof_o, exp_d, (kf == 0));
          data_err++;
        end
        if (b_sof_o) begin
          sofs++;
          if (c0 < 0) c0 = c; else if (c1 < 0) c1 = c;
        end
        k++;
      end
      if (acc) begin
        acc_cnt++;
        b_in_data = 16'(acc_cnt);
        b_in_sof = 1'b0;
      end
    end
    chk("stream_pulses", k, 512);
    chk("stream_data_errors", data_err, 0);
    chk("stream_sof_count", sofs, 2);
    chk("stream_frame_cycles_in_range", (c1 - c0 >= 256) && (c1 - c0 <= 272), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
